// File: rtl/rv32i_types.sv
// rv32i_types: shared types for the RV32I pipeline memory stage.
//   load_align_t  - which lane of the fetched word a load selects
//   cntrl_sigs_t  - per-instruction control bits carried down the pipe
//   ex_mem_reg_t  - EX/MEM pipeline register contents
//   mem_wb_reg_t  - MEM/WB pipeline register contents
//   mem_state_t   - memory stage FSM state
//   mem_req_t     - latched data-cache request
// Helpers: store_shift (lane-shift store data), make_wb (build MEM/WB entry).
package rv32i_types;

  localparam logic [31:0] ADDR_WORD_MASK = 32'hFFFF_FFFC;

  // funct3 encodings of the load instructions
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [2:0] {
    la_nothing,
    la_lw,
    la_lhw_l,
    la_lhw_u,
    la_lb_l,
    la_lb_ml,
    la_lb_mu,
    la_lb_u
  } load_align_t;

  typedef enum logic {
    IDLE,
    REQ
  } mem_state_t;

  typedef struct packed {
    logic        valid_rvfi;
    logic        mem_read;
    logic        mem_write;
    logic        load_reg;
    load_align_t load_align;
  } cntrl_sigs_t;

  typedef struct packed {
    cntrl_sigs_t cntrl_sigs;
    logic [31:0] instruction;
    logic [31:0] pc;
    logic [31:0] pcplus4;
    logic [31:0] alu_out;
    logic [31:0] rs2;
    logic [3:0]  mem_byte_enable;
    logic [4:0]  rd;
  } ex_mem_reg_t;

  typedef struct packed {
    cntrl_sigs_t cntrl_sigs;
    logic [31:0] instruction;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] alu_out;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic [4:0]  rd;
  } mem_wb_reg_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        read;
    logic        write;
  } mem_req_t;

  // Place store data on the byte lanes addressed by the low address bits;
  // bytes shifted past bit 31 are dropped.
  function automatic logic [31:0] store_shift(input logic [31:0] rs2,
                                              input logic [1:0]  offset);
    return rs2 << {offset, 3'b000};
  endfunction

  function automatic mem_wb_reg_t make_wb(input ex_mem_reg_t ex,
                                          input logic [31:0] wdata,
                                          input logic [31:0] rdata);
    mem_wb_reg_t wb;
    wb             = '0;
    wb.cntrl_sigs  = ex.cntrl_sigs;
    wb.instruction = ex.instruction;
    wb.pc          = ex.pc;
    wb.pc_plus4    = ex.pcplus4;
    wb.alu_out     = ex.alu_out;
    wb.mem_addr    = ex.alu_out;
    wb.mem_wdata   = wdata;
    wb.mem_rdata   = rdata;
    wb.rd          = ex.rd;
    return wb;
  endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// mem_load_align: combinational load lane select and extension.
// Ports:
//   rdata      in  32  raw word from the data cache
//   load_align in  3   lane selector (load_align_t)
//   funct3     in  3   load funct3; lb/lh sign-extend, lbu/lhu zero-extend
//   value      out 32  aligned, extended load value
// Kept standalone so the RVFI checker can reuse the same alignment rules.
module mem_load_align
  import rv32i_types::*;
(
  input  logic [31:0] rdata,
  input  load_align_t load_align,
  input  logic [2:0]  funct3,
  output logic [31:0] value
);

  logic        sext;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    value    = '0;
    byte_sel = '0;
    half_sel = '0;
    sext     = (funct3 == F3_LB) || (funct3 == F3_LH);
    case (load_align)
      la_lw: value = rdata;
      la_lhw_l, la_lhw_u: begin
        half_sel = (load_align == la_lhw_u) ? rdata[31:16] : rdata[15:0];
        value    = {{16{sext & half_sel[15]}}, half_sel};
      end
      la_lb_l, la_lb_ml, la_lb_mu, la_lb_u: begin
        case (load_align)
          la_lb_ml: byte_sel = rdata[15:8];
          la_lb_mu: byte_sel = rdata[23:16];
          la_lb_u:  byte_sel = rdata[31:24];
          default:  byte_sel = rdata[7:0];
        endcase
        value = {{24{sext & byte_sel[7]}}, byte_sel};
      end
      default: value = '0;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: memory stage of the 5-stage RV32I pipeline.
// Takes the EX/MEM register, issues registered load/store requests to the
// data cache, stalls upstream until the cache responds, aligns load data and
// produces the MEM/WB register plus the aligned load value.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   ex_mem_i             EX/MEM register contents
//   dmem_address         word-aligned request address
//   dmem_read/write      request kind, held until dmem_resp
//   dmem_wdata           lane-shifted store data
//   dmem_byte_enable     store byte mask (0 for loads)
//   dmem_rdata           cache read data, valid with dmem_resp
//   dmem_resp            one-cycle completion pulse
//   mem_stall_o          upstream holds EX/MEM and earlier stages while high
//   mem_wb_o             MEM/WB register
//   mem_wb_load_data_o   aligned load value, registered with mem_wb_o
//   error_o              sticky watchdog timeout flag
// Handshake: a request is live while dmem_read or dmem_write is high; all
// dmem_* outputs are stable until the cycle dmem_resp is sampled high, which
// completes it. dmem_resp in any other cycle is ignored.
// FSM state is visible as state_q for checkers.
module mem_stage
  import rv32i_types::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  ex_mem_reg_t ex_mem_i,
  output logic [31:0] dmem_address,
  output logic        dmem_read,
  output logic        dmem_write,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_byte_enable,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_resp,
  output logic        mem_stall_o,
  output mem_wb_reg_t mem_wb_o,
  output logic [31:0] mem_wb_load_data_o,
  output logic        error_o
);

  // With the watchdog disabled the counter simply saturates at all-ones.
  localparam logic [31:0] WD_MAX = (TIMEOUT_CYCLES == 0) ? 32'hFFFF_FFFF
                                                        : 32'(TIMEOUT_CYCLES);
  localparam logic WD_ENABLED = (TIMEOUT_CYCLES != 0);

  mem_state_t  state_q, state_d;
  mem_req_t    req_q, req_d;
  mem_wb_reg_t wb_d;
  logic [31:0] load_data_d;
  logic [31:0] wd_cnt_q, wd_cnt_d;
  logic        error_d;

  logic        is_valid;
  logic        is_mem_op;
  logic [31:0] aligned_load;

  assign is_valid  = ex_mem_i.cntrl_sigs.valid_rvfi;
  assign is_mem_op = is_valid &
                     (ex_mem_i.cntrl_sigs.mem_read | ex_mem_i.cntrl_sigs.mem_write);

  assign dmem_address     = req_q.addr;
  assign dmem_read        = req_q.read;
  assign dmem_write       = req_q.write;
  assign dmem_wdata       = req_q.wdata;
  assign dmem_byte_enable = req_q.be;

  mem_load_align u_load_align (
    .rdata      (dmem_rdata),
    .load_align (ex_mem_i.cntrl_sigs.load_align),
    .funct3     (ex_mem_i.instruction[14:12]),
    .value      (aligned_load)
  );

  // Next-state, request, MEM/WB and stall logic. Anything not loaded with a
  // real instruction becomes an all-zero bubble.
  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    wb_d        = '0;
    load_data_d = '0;
    wd_cnt_d    = wd_cnt_q;
    mem_stall_o = 1'b0;

    case (state_q)
      IDLE: begin
        wd_cnt_d = '0;
        if (is_mem_op) begin
          mem_stall_o = 1'b1;
          state_d     = REQ;
          req_d.addr  = ex_mem_i.alu_out & ADDR_WORD_MASK;
          req_d.read  = ex_mem_i.cntrl_sigs.mem_read;
          req_d.write = ex_mem_i.cntrl_sigs.mem_write;
          req_d.wdata = ex_mem_i.cntrl_sigs.mem_write
                        ? store_shift(ex_mem_i.rs2, ex_mem_i.alu_out[1:0]) : '0;
          req_d.be    = ex_mem_i.cntrl_sigs.mem_write
                        ? ex_mem_i.mem_byte_enable : 4'b0000;
        end else if (is_valid) begin
          wb_d = make_wb(ex_mem_i, 32'h0, 32'h0);
        end
      end

      REQ: begin
        if (dmem_resp) begin
          // ex_mem_i still holds the memory instruction because of the stall.
          state_d     = IDLE;
          req_d.read  = 1'b0;
          req_d.write = 1'b0;
          wd_cnt_d    = '0;
          wb_d        = make_wb(ex_mem_i, req_q.wdata,
                                req_q.read ? dmem_rdata : 32'h0);
          load_data_d = req_q.read ? aligned_load : 32'h0;
        end else begin
          mem_stall_o = 1'b1;
          if (wd_cnt_q != WD_MAX) begin
            wd_cnt_d = wd_cnt_q + 32'd1;
          end
        end
      end

      default: state_d = IDLE;
    endcase

    error_d = error_o | (WD_ENABLED & (wd_cnt_d == WD_MAX));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q            <= IDLE;
      req_q              <= '0;
      mem_wb_o           <= '0;
      mem_wb_load_data_o <= '0;
      wd_cnt_q           <= '0;
      error_o            <= 1'b0;
    end else begin
      state_q            <= state_d;
      req_q              <= req_d;
      mem_wb_o           <= wb_d;
      mem_wb_load_data_o <= load_data_d;
      wd_cnt_q           <= wd_cnt_d;
      error_o            <= error_d;
    end
  end

endmodule
